// File: rtl/layer_sched_pkg.sv
// Shared types and defaults for the layer sequencer (layer_sched and argmax_track).
package layer_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_STORE,
    S_DONE
  } state_t;

  localparam int NODES_DEF   = 10;
  localparam int CHUNKS_DEF  = 49;
  localparam int MAC_LAT_DEF = 3;
  localparam int DATA_W      = 8;
  localparam int BEAT_W      = 128;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/argmax_track.sv
// Running max / index register; lower index wins ties. Used only with LAYER_SCHED_ARGMAX_EN.
module argmax_track
  import layer_sched_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd,
  input  logic              first,
  input  logic [DATA_W-1:0] value,
  input  logic [IDX_W-1:0]  idx,
  input  logic              set_valid,
  input  logic              clr_valid,
  output logic [3:0]        pred_idx,
  output logic              pred_valid
);

  logic [DATA_W-1:0] max_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_val    <= '0;
      pred_idx   <= '0;
      pred_valid <= 1'b0;
    end else begin
      if (upd && (first || value > max_val)) begin
        max_val  <= value;
        pred_idx <= 4'(idx);
      end
      if (clr_valid)
        pred_valid <= 1'b0;
      else if (set_valid)
        pred_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/layer_sched.sv
// Fully-connected layer sequencer sharing one neuron datapath across all nodes.
// Optional argmax tracking is enabled by defining LAYER_SCHED_ARGMAX_EN.
module layer_sched
  import layer_sched_pkg::*;
#(
  parameter int NODES   = NODES_DEF,
  parameter int CHUNKS  = CHUNKS_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  mem_rd,
  output logic [clog2_min1(CHUNKS)-1:0]         pix_addr,
  output logic [clog2_min1(NODES*CHUNKS)-1:0]   w_addr,
  output logic [clog2_min1(NODES)-1:0]          node_idx,
  output logic                                  mac_clr,
  output logic                                  mac_en,
  input  logic [DATA_W-1:0]                     node_out,
  output logic                                  out_we,
  output logic [clog2_min1(NODES)-1:0]          out_addr,
  output logic [DATA_W-1:0]                     out_data,
  output logic [3:0]                            pred_idx,
  output logic                                  pred_valid
);

  localparam int CW = clog2_min1(CHUNKS);
  localparam int WW = clog2_min1(NODES*CHUNKS);
  localparam int NW = clog2_min1(NODES);
  localparam int DW = clog2_min1(MAC_LAT + 1);

  state_t        state, next_state;
  logic [CW-1:0] chunk;
  logic [WW-1:0] w_cnt;
  logic [NW-1:0] node;
  logic [DW-1:0] drain_cnt;
  logic          last_chunk, last_node, drain_done;

  assign last_chunk = (chunk == CW'(CHUNKS - 1));
  assign last_node  = (node == NW'(NODES - 1));
  assign drain_done = (drain_cnt == DW'(MAC_LAT));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (start) next_state = S_CLEAR;
      S_CLEAR: next_state = S_FEED;
      S_FEED:  if (last_chunk) next_state = S_DRAIN;
      S_DRAIN: if (drain_done) next_state = S_STORE;
      S_STORE: next_state = last_node ? S_DONE : S_CLEAR;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    mem_rd  = 1'b0;
    mac_clr = 1'b0;
    out_we  = 1'b0;
    unique case (state)
      S_CLEAR: begin busy = 1'b1; mac_clr = 1'b1; end
      S_FEED:  begin busy = 1'b1; mem_rd  = 1'b1; end
      S_DRAIN: busy = 1'b1;
      S_STORE: begin busy = 1'b1; out_we  = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // w_cnt only advances during FEED, so it lands on node*CHUNKS at each CLEAR
  // without a multiplier; it is rewound only when a new run is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      chunk     <= '0;
      w_cnt     <= '0;
      node      <= '0;
      drain_cnt <= '0;
      mac_en    <= 1'b0;
    end else begin
      mac_en <= mem_rd;
      unique case (state)
        S_IDLE: if (start) begin
          node  <= '0;
          w_cnt <= '0;
        end
        S_CLEAR: chunk <= '0;
        S_FEED: begin
          w_cnt     <= w_cnt + WW'(1);
          drain_cnt <= '0;
          if (!last_chunk) chunk <= chunk + CW'(1);
        end
        S_DRAIN: drain_cnt <= drain_cnt + DW'(1);
        S_STORE: if (!last_node) node <= node + NW'(1);
        default: ;
      endcase
    end
  end

  assign pix_addr = chunk;
  assign w_addr   = w_cnt;
  assign node_idx = node;
  assign out_addr = node;
  assign out_data = out_we ? node_out : '0;

`ifdef LAYER_SCHED_ARGMAX_EN
  argmax_track #(.IDX_W(NW)) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .upd        (state == S_STORE),
    .first      (node == '0),
    .value      (node_out),
    .idx        (node),
    .set_valid  ((state == S_STORE) && last_node),
    .clr_valid  ((state == S_IDLE) && start),
    .pred_idx   (pred_idx),
    .pred_valid (pred_valid)
  );
`else
  assign pred_idx   = '0;
  assign pred_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sched.sv
// Table-driven bench for layer_sched with NODES=3, CHUNKS=4, MAC_LAT=2.
module tb_layer_sched;

  localparam int N    = 3;
  localparam int CH   = 4;
  localparam int ML   = 2;
  localparam int P    = CH + ML + 3;
  localparam int LAST = N * P + 1;
`ifdef LAYER_SCHED_ARGMAX_EN
  localparam int ARGMAX = 1;
`else
  localparam int ARGMAX = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, start;
  logic       busy, done, mem_rd, mac_clr, mac_en, out_we, pred_valid;
  logic [1:0] pix_addr, node_idx, out_addr;
  logic [3:0] w_addr, pred_idx;
  logic [7:0] node_out, out_data;

  always #5 clk = ~clk;

  layer_sched #(.NODES(N), .CHUNKS(CH), .MAC_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .pix_addr(pix_addr), .w_addr(w_addr), .node_idx(node_idx),
    .mac_clr(mac_clr), .mac_en(mac_en), .node_out(node_out), .out_we(out_we),
    .out_addr(out_addr), .out_data(out_data), .pred_idx(pred_idx),
    .pred_valid(pred_valid)
  );

  typedef struct {
    bit busy, done, mem_rd, mac_clr, mac_en, out_we;
    int pix, w, node, oaddr, odata;
  } vec_t;

  vec_t tbl[LAST+1];
  int   vals[N] = '{40, 200, 200};
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " mem_rd"}, mem_rd, 0);
    chk({tag, " mac_clr"}, mac_clr, 0);
    chk({tag, " mac_en"}, mac_en, 0);
    chk({tag, " out_we"}, out_we, 0);
    chk({tag, " pix_addr"}, pix_addr, 0);
    chk({tag, " w_addr"}, w_addr, 0);
    chk({tag, " node_idx"}, node_idx, 0);
    chk({tag, " out_addr"}, out_addr, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " pred_idx"}, pred_idx, 0);
    chk({tag, " pred_valid"}, pred_valid, 0);
  endtask

  // Apply one run from the start cycle (0) through the done cycle (LAST).
  task automatic run_table(input string tag, input bit hold);
    @(negedge clk);
    start = 1'b1;
    node_out = 8'd0;
    #1;
    chk($sformatf("%s c0 busy", tag), busy, 0);
    chk($sformatf("%s c0 done", tag), done, 0);
    for (int c = 1; c <= LAST; c++) begin
      @(negedge clk);
      start = hold;
      node_out = (c <= N * P) ? 8'(vals[(c - 1) / P]) : 8'd0;
      #1;
      chk($sformatf("%s c%0d busy", tag, c), busy, tbl[c].busy);
      chk($sformatf("%s c%0d done", tag, c), done, tbl[c].done);
      chk($sformatf("%s c%0d mem_rd", tag, c), mem_rd, tbl[c].mem_rd);
      chk($sformatf("%s c%0d mac_clr", tag, c), mac_clr, tbl[c].mac_clr);
      chk($sformatf("%s c%0d mac_en", tag, c), mac_en, tbl[c].mac_en);
      chk($sformatf("%s c%0d out_we", tag, c), out_we, tbl[c].out_we);
      if (tbl[c].mem_rd) begin
        chk($sformatf("%s c%0d pix_addr", tag, c), pix_addr, tbl[c].pix);
        chk($sformatf("%s c%0d w_addr", tag, c), w_addr, tbl[c].w);
      end
      if (tbl[c].busy)
        chk($sformatf("%s c%0d node_idx", tag, c), node_idx, tbl[c].node);
      if (tbl[c].out_we) begin
        chk($sformatf("%s c%0d out_addr", tag, c), out_addr, tbl[c].oaddr);
        chk($sformatf("%s c%0d out_data", tag, c), out_data, tbl[c].odata);
      end
      if (c == 1)
        chk($sformatf("%s c1 pred_valid", tag), pred_valid, 0);
      if (c == LAST) begin
        chk($sformatf("%s done pred_valid", tag), pred_valid, ARGMAX);
        chk($sformatf("%s done pred_idx", tag), pred_idx, ARGMAX);
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    for (int c = 0; c <= LAST; c++) begin
      tbl[c] = '{default: 0};
      if (c >= 1 && c <= N * P) begin
        int n, r;
        n = (c - 1) / P;
        r = (c - 1) % P;
        tbl[c].busy    = 1'b1;
        tbl[c].node    = n;
        tbl[c].mac_clr = (r == 0);
        tbl[c].mem_rd  = (r >= 1 && r <= CH);
        tbl[c].pix     = r - 1;
        tbl[c].w       = n * CH + r - 1;
        tbl[c].mac_en  = (r >= 2 && r <= CH + 1);
        tbl[c].out_we  = (r == P - 1);
        tbl[c].oaddr   = n;
        tbl[c].odata   = vals[n];
      end
      if (c == LAST) tbl[c].done = 1'b1;
    end

    rst = 1'b1;
    start = 1'b0;
    node_out = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    run_table("runA", 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("postA%0d busy", k), busy, 0);
      chk($sformatf("postA%0d done", k), done, 0);
      chk($sformatf("postA%0d pred_valid", k), pred_valid, ARGMAX);
      chk($sformatf("postA%0d pred_idx", k), pred_idx, ARGMAX);
    end

    // start held high through the whole run and into the following IDLE.
    run_table("held", 1'b1);
    @(negedge clk);
    #1;
    chk("held c29 busy", busy, 0);
    chk("held c29 mac_clr", mac_clr, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("held c30 mac_clr", mac_clr, 1);
    chk("held c30 busy", busy, 1);
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      #1;
      if (done) seen = k + 1;
    end
    chk("held second run done cycles after c30", seen, LAST - 1);

    // Reset during node 1 FEED.
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 12) begin
        #1;
        chk("abort c12 mem_rd", mem_rd, 1);
        chk("abort c12 node_idx", node_idx, 1);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    #1;
    check_all_zero("abort c13");
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("abort idle%0d done", k), done, 0);
      chk($sformatf("abort idle%0d busy", k), busy, 0);
    end
    run_table("fresh", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/layer_sched.md
# layer_sched

Sequencer for one fully-connected layer of the digit-recognition network. It shares a single neuron datapath (MAC accumulator plus sigmoid, 16 pixel/weight byte pairs per beat) across all nodes of the layer. For each node it clears the accumulator, streams `CHUNKS` beats of pixel/weight addresses to the memories and waits out the datapath latency. It then writes the 8-bit activation into the layer output buffer. It sits between the top-level control FSM (start/done) and the datapath, pixel RAM, weight ROM, bias ROM and output RAM.

## Interface
- `NODES`, 10, nodes in the layer (≥1)
- `CHUNKS`, 49, 128-bit beats per node (784 pixels / 16)
- `MAC_LAT`, 3, cycles from the last `mac_en` beat to a valid `node_out`
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  start request; sampled only in IDLE
- `busy`  out  1  high in CLEAR/FEED/DRAIN/STORE
- `done`  out  1  one-cycle pulse when the layer is complete
- `mem_rd`  out  1  read strobe to pixel RAM and weight ROM; data is returned one cycle later
- `pix_addr`  out  clog2(CHUNKS)  pixel beat address
- `w_addr`  out  clog2(NODES*CHUNKS)  weight beat address
- `node_idx`  out  clog2(NODES) (min 1)  current node; drives the bias ROM address
- `mac_clr`  out  1  clears the accumulator
- `mac_en`  out  1  beat valid into the accumulator (`mem_rd` delayed 1 cycle)
- `node_out`  in  8  sigmoid output of the datapath
- `out_we`  out  1  output buffer write enable
- `out_addr`  out  clog2(NODES)  output buffer address
- `out_data`  out  8  activation to store
- `pred_idx`  out  4  argmax node index (see Configuration)
- `pred_valid`  out  1  `pred_idx` valid

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, STORE, DONE.
- **IDLE**
  - `start` moves to CLEAR with node=0.
  - `start` is ignored in every other state.
- **CLEAR**
  - `mac_clr`=1 for one cycle; chunk=0.
  - Moves to FEED.
- **FEED**
  - `mem_rd`=1, `pix_addr`=chunk, `w_addr`=node*CHUNKS+chunk.
  - `w_addr` comes from a running counter; no multiplier.
  - chunk==CHUNKS-1 moves to DRAIN; otherwise chunk++.
- **DRAIN**
  - Waits MAC_LAT+1 cycles (memory latency plus datapath latency), then moves to STORE.
- **STORE**
  - `out_we`=1, `out_addr`=node, `out_data`=`node_out`.
  - node==NODES-1 moves to DONE; otherwise node++ and moves to CLEAR.
- **DONE**: `done`=1 for one cycle, then moves to IDLE.
- `node_idx` holds the current node from CLEAR through STORE, so the bias is stable for the whole accumulation.
- `w_addr` does not reset between nodes; it wraps to 0 only on a new start.
- Reset values: every output is 0, state=IDLE, all counters 0.
- `rst` mid-operation aborts at the next edge, with no `done` and no further `out_we`. The accumulator is cleared by the CLEAR that follows the next start.

## Timing
- Cycles per node: P = CHUNKS + MAC_LAT + 3.
- With `start` sampled in cycle 0:
  - CLEAR of node n is in cycle 1 + n·P.
  - STORE of node n is in cycle (n+1)·P.
  - `done` is in cycle NODES·P + 1.
- Defaults give P=55 and `done` at cycle 551.
- `mac_en` is high for exactly CHUNKS consecutive cycles per node, starting the cycle after CLEAR+1.
- `busy` falls in the DONE cycle.
- `start` held high through DONE launches the next run one cycle after `done`, once IDLE is re-entered.

## Configuration
- Macro: `LAYER_SCHED_ARGMAX_EN`.
- **Defined**:
  - On each STORE, if node==0 or `node_out` > max (unsigned, strict), update max and `pred_idx`. Ties keep the lower index.
  - `pred_valid` rises with `done` and holds until the next accepted start or `rst`.
  - `pred_idx` holds between runs.
- **Undefined**: `pred_idx`=0 and `pred_valid`=0 constantly; no tracking registers are synthesised.

## Structure
- `layer_sched_pkg` holds:
  - the state enum
  - default `NODES`/`CHUNKS`/`MAC_LAT`
  - the `DATA_W`=8 and `BEAT_W`=128 constants
- Sub-module `argmax_track` (running max/index register with the update rule above) is instantiated only under `LAYER_SCHED_ARGMAX_EN`.

## Test plan
- NODES=3, CHUNKS=4, MAC_LAT=2: `start` in cycle 0 gives:
  - `mac_clr` in cycles 1/10/19
  - `out_we` in cycles 9/18/27 with `out_addr` 0/1/2
  - `done` in cycle 28, single pulse
- Address sweep (same config): `w_addr` runs 0..11 with no gaps; `pix_addr` runs 0..3 three times; `mac_en` lags `mem_rd` by exactly 1 cycle.
- `start` held high for the entire run: exactly one run; a second run begins at cycle 29 (one cycle after `done`).
- `rst` asserted in cycle 12 (node 1, FEED): from cycle 13, all outputs are 0 and state is IDLE; there is no `done`; a fresh start completes in 28 cycles.
- With `LAYER_SCHED_ARGMAX_EN`: `node_out` returns 40, 200, 200 → `pred_idx`=1 and `pred_valid`=1 from `done` until the next start.
- Without `LAYER_SCHED_ARGMAX_EN`: the same stimulus gives `pred_idx`=0 and `pred_valid`=0 throughout.
